// File: rtl/bit_lane_packer.sv
// rtl/bit_lane_packer.sv - packs one or two bit lanes per beat into WIDTH-bit valid/ready words
module bit_lane_packer #(
    parameter int         WIDTH     = 8,
    parameter logic [1:0] LANE_MASK = 2'b11,
    parameter int         CNT_W     = 16
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic                         I0,
    input  logic                         I1,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(WIDTH+1)-1:0]   beat_cnt,
    output logic [CNT_W-1:0]             word_cnt
);

    localparam int BPB      = int'(LANE_MASK[0]) + int'(LANE_MASK[1]);
    localparam int BPB_SAFE = (BPB == 0) ? 1 : BPB;
    localparam int BCW      = $clog2(WIDTH + 1);

    generate
        if (LANE_MASK == 2'b00) begin : g_bad_mask
            $error("bit_lane_packer: LANE_MASK must select at least one lane");
        end
        if ((WIDTH % BPB_SAFE) != 0) begin : g_bad_width
            $error("bit_lane_packer: WIDTH must be a multiple of the used lane count");
        end
    endgenerate

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_with_beat;
    logic [1:0]       beat_bits;
    logic [BCW-1:0]   cnt_after;
    logic             flush_pend;
    logic             flush_eff;
    logic             accept;
    logic             complete;
    logic             service;
    logic             emit;

    assign in_ready  = RESETN && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign flush_eff = flush || flush_pend;

    // Select only the used lanes; an unused lane never enters the datapath.
    always_comb begin
        beat_bits = 2'b00;
        if (BPB == 2) begin
            beat_bits = {I1, I0};
        end else if (LANE_MASK[0]) begin
            beat_bits = {1'b0, I0};
        end else begin
            beat_bits = {1'b0, I1};
        end
    end

    // Accumulator image and bit count including this cycle's accepted beat.
    always_comb begin
        acc_with_beat = acc;
        cnt_after     = beat_cnt;
        if (accept) begin
            acc_with_beat = acc | (WIDTH'(beat_bits) << beat_cnt);
            cnt_after     = beat_cnt + BCW'(BPB);
        end
    end

    assign complete = accept && (beat_cnt == BCW'(WIDTH - BPB));
    assign service  = flush_eff && in_ready && (cnt_after != '0) && !complete;
    assign emit     = complete || service;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a word is held until handshaken, back-to-back emits stay FULL.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (emit) state_next = FULL;
            FULL:    if (out_ready && !emit) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // State outputs.
    always_comb begin
        out_valid = (state == FULL);
    end

    // Packing datapath: accumulate beats, move finished or flushed word to the output.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            acc      <= '0;
            beat_cnt <= '0;
            out_data <= '0;
            word_cnt <= '0;
        end else if (emit) begin
            out_data <= acc_with_beat;
            acc      <= '0;
            beat_cnt <= '0;
            word_cnt <= word_cnt + 1'b1;
        end else if (accept) begin
            acc      <= acc_with_beat;
            beat_cnt <= cnt_after;
        end
    end

    // Pending flush survives only while the packer cannot take a beat.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            flush_pend <= 1'b0;
        end else if (in_ready) begin
            flush_pend <= 1'b0;
        end else begin
            flush_pend <= flush_eff;
        end
    end

endmodule

// File: tb/tb_bit_lane_packer.sv
// tb/tb_bit_lane_packer.sv - scoreboard bench for bit_lane_packer (8-bit two-lane and 4-bit lane-0 instances)
module tb_bit_lane_packer;

    logic        clk;
    logic        rn;
    logic        iv0, i00, i10, fl0, ordy0;
    logic        ir0, ov0;
    logic [7:0]  od0;
    logic [3:0]  bc0;
    logic [15:0] wc0;
    logic        iv1, i01, i11, fl1, ordy1;
    logic        ir1, ov1;
    logic [3:0]  od1;
    logic [2:0]  bc1;
    logic [1:0]  wc1;

    int n_tests;
    int n_fail;

    bit_lane_packer #(.WIDTH(8), .LANE_MASK(2'b11), .CNT_W(16)) dut0 (
        .CLK(clk), .RESETN(rn), .I0(i00), .I1(i10), .in_valid(iv0), .in_ready(ir0),
        .flush(fl0), .out_data(od0), .out_valid(ov0), .out_ready(ordy0),
        .beat_cnt(bc0), .word_cnt(wc0)
    );

    bit_lane_packer #(.WIDTH(4), .LANE_MASK(2'b01), .CNT_W(2)) dut1 (
        .CLK(clk), .RESETN(rn), .I0(i01), .I1(i11), .in_valid(iv1), .in_ready(ir1),
        .flush(fl1), .out_data(od1), .out_valid(ov1), .out_ready(ordy1),
        .beat_cnt(bc1), .word_cnt(wc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a bit list per instance, words emitted but not yet taken sit in a queue.
    int         nb[2];
    logic [7:0] acc_m[2];
    bit         pend[2];
    int         cnt_m[2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qfront(input int id);
        if (id == 0) return (q0.size() > 0) ? q0[0] : 8'h00;
        return (q1.size() > 0) ? q1[0] : 8'h00;
    endfunction

    task automatic qpush(input int id, input logic [7:0] v);
        if (id == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic qpop(input int id);
        if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    task automatic qclear(input int id);
        if (id == 0) q0.delete(); else q1.delete();
    endtask

    task automatic model_step(input int id, input int w, input logic [1:0] mask, input int cw,
                              input logic r, input logic iv, input logic i0, input logic i1,
                              input logic fl, input logic ordy);
        bit ov_m;
        bit ir_m;
        bit done;
        if (!r) begin
            nb[id] = 0; acc_m[id] = 8'h00; pend[id] = 1'b0; cnt_m[id] = 0;
            qclear(id);
        end else begin
            ov_m = (qsize(id) > 0);
            ir_m = !ov_m || ordy;
            done = 1'b0;
            if (ov_m && ordy) qpop(id);
            if (fl) pend[id] = 1'b1;
            if (ir_m) begin
                if (iv) begin
                    if (mask[0]) begin acc_m[id][nb[id]] = i0; nb[id]++; end
                    if (mask[1]) begin acc_m[id][nb[id]] = i1; nb[id]++; end
                    done = (nb[id] == w);
                end
                if (done || (pend[id] && nb[id] > 0)) begin
                    qpush(id, acc_m[id]);
                    cnt_m[id] = (cnt_m[id] + 1) % (1 << cw);
                    acc_m[id] = 8'h00;
                    nb[id] = 0;
                end
                pend[id] = 1'b0;
            end
        end
    endtask

    // Advance the model on each edge from the values the DUT samples.
    always @(posedge clk) begin
        model_step(0, 8, 2'b11, 16, rn, iv0, i00, i10, fl0, ordy0);
        model_step(1, 4, 2'b01, 2, rn, iv1, i01, i11, fl1, ordy1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        check("in_ready0", {31'd0, ir0}, {31'd0, rn && (qsize(0) == 0 || ordy0)});
        check("out_valid0", {31'd0, ov0}, {31'd0, qsize(0) > 0});
        check("beat_cnt0", {28'd0, bc0}, nb[0]);
        check("word_cnt0", {16'd0, wc0}, cnt_m[0]);
        if (qsize(0) > 0) check("out_data0", {24'd0, od0}, {24'd0, qfront(0)});
        check("in_ready1", {31'd0, ir1}, {31'd0, rn && (qsize(1) == 0 || ordy1)});
        check("out_valid1", {31'd0, ov1}, {31'd0, qsize(1) > 0});
        check("beat_cnt1", {29'd0, bc1}, nb[1]);
        check("word_cnt1", {30'd0, wc1}, cnt_m[1]);
        if (qsize(1) > 0) check("out_data1", {28'd0, od1}, {24'd0, qfront(1)});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic beat0(input logic a, input logic b);
        iv0 = 1'b1; i00 = a; i10 = b;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        logic [3:0] pat;
        n_tests = 0; n_fail = 0;
        rn = 1'b0;
        iv0 = 0; i00 = 0; i10 = 0; fl0 = 0; ordy0 = 1;
        iv1 = 0; i01 = 0; i11 = 1'bx; fl1 = 0; ordy1 = 1;
        tick(); tick();
        check("rst_in_ready", {31'd0, ir0}, 32'd0);
        check("rst_out_valid", {31'd0, ov0}, 32'd0);
        check("rst_out_data", {24'd0, od0}, 32'd0);
        check("rst_word_cnt", {16'd0, wc0}, 32'd0);
        check("rst_beat_cnt", {28'd0, bc0}, 32'd0);
        rn = 1'b1;
        tick();

        // Four beats on two lanes form 8'h39.
        beat0(1, 0); beat0(0, 1); beat0(1, 1); beat0(0, 0);
        iv0 = 0;
        check("w39_valid", {31'd0, ov0}, 32'd1);
        check("w39_data", {24'd0, od0}, 32'h39);
        check("w39_cnt", {16'd0, wc0}, 32'd1);
        tick();
        check("w39_one_cycle", {31'd0, ov0}, 32'd0);

        // Lane 0 only; lane 1 is garbage.
        pat = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            iv1 = 1; i01 = pat[k]; i11 = (k % 2 == 0) ? 1'bx : 1'b1;
            tick();
            if (k < 3) check("w4_beat_cnt", {29'd0, bc1}, k + 1);
        end
        iv1 = 0;
        check("w4_beat_cnt_wrap", {29'd0, bc1}, 32'd0);
        check("w4_data", {28'd0, od1}, 32'hD);
        check("w4_valid", {31'd0, ov1}, 32'd1);
        tick();

        // Flush a partial word of three (1,1) beats.
        beat0(1, 1); beat0(1, 1); beat0(1, 1);
        iv0 = 0; fl0 = 1;
        tick();
        fl0 = 0;
        for (int k = 0; k < 6 && ov0 !== 1'b1; k++) tick();
        check("flush_valid", {31'd0, ov0}, 32'd1);
        check("flush_data", {24'd0, od0}, 32'h3F);
        check("flush_beat_cnt", {28'd0, bc0}, 32'd0);
        tick();
        fl0 = 1;
        tick();
        fl0 = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("empty_flush_no_word", {31'd0, ov0}, 32'd0);
        end
        check("empty_flush_cnt", {16'd0, wc0}, 32'd2);

        // Stall with a full word held for five cycles.
        ordy0 = 0;
        beat0(1, 0); beat0(1, 0); beat0(0, 1); beat0(0, 1);
        check("stall_data", {24'd0, od0}, 32'hA5);
        held = od0;
        for (int k = 0; k < 5; k++) begin
            beat0(1, 1);
            check("stall_in_ready", {31'd0, ir0}, 32'd0);
            check("stall_hold", {24'd0, od0}, {24'd0, held});
            check("stall_valid", {31'd0, ov0}, 32'd1);
        end
        ordy0 = 1;
        beat0(1, 1);
        check("stall_release", {31'd0, ov0}, 32'd0);
        beat0(0, 0); beat0(1, 0); beat0(0, 1);
        check("after_stall_data", {24'd0, od0}, 32'h93);
        iv0 = 0;
        tick();

        // Streaming with counter wrap on the narrow instance.
        rn = 0; tick(); rn = 1;
        for (int k = 0; k < 20; k++) begin
            iv0 = (k < 12); i00 = 1'($urandom); i10 = 1'($urandom);
            iv1 = 1; i01 = 1'($urandom); i11 = 1'bx;
            #1;
            check("stream_in_ready0", {31'd0, ir0}, 32'd1);
            check("stream_in_ready1", {31'd0, ir1}, 32'd1);
            tick();
        end
        iv0 = 0; iv1 = 0;
        tick();
        check("stream_words0", {16'd0, wc0}, 32'd3);
        check("stream_wrap1", {30'd0, wc1}, 32'd1);

        // Reset mid-word and mid-stall.
        beat0(1, 1); beat0(1, 1);
        iv0 = 0; rn = 0;
        tick();
        check("midword_rst_valid", {31'd0, ov0}, 32'd0);
        check("midword_rst_data", {24'd0, od0}, 32'd0);
        check("midword_rst_beats", {28'd0, bc0}, 32'd0);
        check("midword_rst_cnt", {16'd0, wc0}, 32'd0);
        check("midword_rst_ready", {31'd0, ir0}, 32'd0);
        rn = 1;
        beat0(0, 0); beat0(0, 0); beat0(0, 0); beat0(1, 0);
        check("clean_word", {24'd0, od0}, 32'h40);
        iv0 = 0;
        tick();
        ordy0 = 0;
        beat0(1, 1); beat0(1, 1); beat0(1, 1); beat0(1, 1);
        iv0 = 0;
        tick(); tick();
        rn = 0;
        tick();
        rn = 1;
        check("stall_rst_valid", {31'd0, ov0}, 32'd0);
        check("stall_rst_data", {24'd0, od0}, 32'd0);
        ordy0 = 1;
        beat0(0, 1); beat0(0, 1); beat0(0, 1); beat0(0, 1);
        check("post_rst_word", {24'd0, od0}, 32'hAA);
        iv0 = 0;
        tick();

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rn    = ($urandom_range(0, 199) != 0);
            iv0   = 1'($urandom); i00 = 1'($urandom); i10 = 1'($urandom);
            fl0   = ($urandom_range(0, 19) == 0);
            ordy0 = ($urandom_range(0, 3) != 0);
            iv1   = 1'($urandom); i01 = 1'($urandom);
            i11   = ($urandom_range(0, 1) == 0) ? 1'bx : 1'($urandom);
            fl1   = ($urandom_range(0, 19) == 0);
            ordy1 = ($urandom_range(0, 3) != 0);
            tick();
        end
        rn = 1; iv0 = 0; iv1 = 0; fl0 = 0; fl1 = 0; ordy0 = 1; ordy1 = 1;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_lane_packer.md
Name: bit_lane_packer

Overview:
- Downstream consumer of a two-bit-lane unit (I0/I1 style outputs, one lane of which may be left undriven).
- Collects per-cycle lane bits into WIDTH-bit words and presents each word on a valid/ready output.
- Lanes marked unused in LANE_MASK are terminated internally: never sampled, never propagated. Undriven upstream outputs therefore never reach packed data.

Parameters:
- WIDTH, 8, packed word width. Must be divisible by BPB (elaboration error otherwise).
- LANE_MASK, 2'b11, bit k=1 means lane k (Ik) is used. 2'b00 is an elaboration error.
- CNT_W, 16, width of the completed-word counter.

Ports:
- CLK  in  1  clock, rising edge.
- RESETN  in  1  synchronous, active-low reset.
- I0  in  1  lane 0 data bit.
- I1  in  1  lane 1 data bit.
- in_valid  in  1  I0/I1 carry a beat this cycle.
- in_ready  out  1  packer accepts a beat this cycle.
- flush  in  1  pulse: emit current partial word zero-padded.
- out_data  out  WIDTH  packed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer takes word.
- beat_cnt  out  $clog2(WIDTH+1)  bits collected into current word.
- word_cnt  out  CNT_W  words emitted, wraps modulo 2^CNT_W.

Behaviour:
- BPB = popcount(LANE_MASK), either 1 or 2. BEATS = WIDTH/BPB.
- Accept condition: in_valid && in_ready.
- in_ready = RESETN && (!out_valid || out_ready). It is combinational. It is 0 while RESETN is low.
- Packing order:
  - LSB first.
  - Within a beat, used lane 0 goes before used lane 1.
  - Beat n occupies bits [n*BPB +: BPB] of the shift/accumulate register.
  - Unused lane inputs are ignored, even if X.
- Word completion:
  - Trigger: accepted beat with beat_cnt == WIDTH-BPB.
  - Next edge: out_data <= accumulated word including that beat, out_valid <= 1, accumulator <= 0, beat_cnt <= 0, word_cnt += 1.
  - Latency from last accepted beat to out_valid is 1 cycle.
- Output handshake:
  - out_valid && out_ready with no completion that cycle: out_valid <= 0. out_data holds its last value.
  - Completion in the same cycle as a handshake: out_valid stays 1 and out_data takes the new word. Full throughput, one word per BEATS cycles.
  - out_valid && !out_ready: out_data and out_valid are held stable. in_ready = 0.
- Flush:
  - A flush pulse sets flush_pend.
  - flush_pend is serviced on the first cycle with in_ready = 1 and beat_cnt (including any beat accepted that cycle) > 0.
  - Service emits the word as a completion would, with upper bits 0.
  - Flush with beat_cnt == 0 and no accepted beat clears flush_pend and emits nothing.
  - Flush coinciding with a natural completion: the completion is emitted and flush_pend is cleared. No empty word follows.
- States:
  - FILL: out_valid=0.
  - FULL: out_valid=1.
  - FILL→FULL on completion or flush service.
  - FULL→FILL on handshake without completion.
  - FULL→FULL on handshake with completion, or on stall.
- Reset (RESETN low at an edge): out_valid=0, out_data=0, accumulator=0, beat_cnt=0, word_cnt=0, flush_pend=0.
  - Reset mid-word discards partial bits.
  - Reset mid-stall drops the held word.
- No X on outputs after reset regardless of unused-lane input values.

Test Plan:
- WIDTH=8, MASK=11, beats (I0,I1) = (1,0),(0,1),(1,1),(0,0) on consecutive cycles, out_ready=1 -> out_data=8'h39, out_valid high exactly 1 cycle, 1 cycle after the 4th beat, word_cnt=1.
- WIDTH=4, MASK=01, I0 = 1,0,1,1 with I1 driven X/toggling -> out_data=4'hD, beat_cnt steps 1,2,3 then 0.
- WIDTH=8, MASK=11, three beats (1,1) then flush pulse -> out_data=8'h3F, beat_cnt=0. A second flush with an empty accumulator emits nothing.
- Word complete with out_ready=0 for 5 cycles -> in_ready=0, out_data stable, upstream beats not accepted. out_ready=1 -> handshake, then filling resumes and the next word packs correctly.
- Streaming 3 words with out_ready=1 and in_valid held high -> no bubbles, in_ready never drops, word_cnt=3. With CNT_W=2, 5 words -> word_cnt=1 (wraps).
- RESETN low for 1 cycle after 2 beats, and again during a stalled FULL state -> all outputs 0. The next 4 beats form a clean word with no residue.
